// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first through a single borrow flip-flop,
// sequenced by a two-state IDLE/SHIFT controller with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start_i; results held on diff_o/borrow_o
// SHIFT | one operand bit consumed per clock, WIDTH clocks total
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic [WIDTH-1:0] r_acc, w_acc_nxt;
   logic [WIDTH-1:0] r_diff, w_diff_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_br, w_br_nxt;
   logic             r_borrow, w_borrow_nxt;
   logic             r_done, w_done_nxt;

   logic             w_d;
   logic             w_br_out;
   logic [WIDTH-1:0] w_acc_shift;

   // Serial ALU: one full-subtractor bit, borrow feeds back through r_br.
   assign w_d         = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_out    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_acc_shift = {w_d, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_br     <= 1'b0;
         r_borrow <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_acc    <= w_acc_nxt;
         r_diff   <= w_diff_nxt;
         r_cnt    <= w_cnt_nxt;
         r_br     <= w_br_nxt;
         r_borrow <= w_borrow_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_acc_nxt    = r_acc;
      w_diff_nxt   = r_diff;
      w_cnt_nxt    = r_cnt;
      w_br_nxt     = r_br;
      w_borrow_nxt = r_borrow;
      w_done_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_a_nxt     = a_i;
               w_b_nxt     = b_i;
               w_acc_nxt   = '0;
               w_br_nxt    = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_a_nxt   = r_a >> 1;
            w_b_nxt   = r_b >> 1;
            w_acc_nxt = w_acc_shift;
            w_br_nxt  = w_br_out;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
               // Last bit: publish result in the same edge that shifts it in.
               w_diff_nxt   = w_acc_shift;
               w_borrow_nxt = w_br_out;
               w_done_nxt   = 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy_o   = (r_state == SHIFT);
   assign done_o   = r_done;
   assign diff_o   = r_diff;
   assign borrow_o = r_borrow;

endmodule
